// File: rtl/matriz_varredura.sv
// rtl/matriz_varredura.sv - 7x5 LED matrix row scan controller (row code, blanking, active-low columns)
// Optional display time slot after row 7 is enabled by defining MATRIZ_DISPLAY_SLOT_EN.
module matriz_varredura #(
    parameter int DIV   = 4,
    parameter int BLANK = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       habilita,
    input  logic       wr_en,
    input  logic [2:0] wr_linha,
    input  logic [4:0] wr_dados,
    output logic       CH2,
    output logic       CH1,
    output logic       CH0,
    output logic       valido,
    output logic [4:0] colunas,
    output logic       fim_quadro
);

`ifdef MATRIZ_DISPLAY_SLOT_EN
    typedef enum logic [1:0] {IDLE, APAGA, ACESA, DISP} estado_t;
`else
    typedef enum logic [1:0] {IDLE, APAGA, ACESA} estado_t;
`endif

    localparam int CW = $clog2(DIV + BLANK + 1);
    localparam logic [CW-1:0] FIM_ACESA = CW'(DIV - 1);
    localparam logic [CW-1:0] FIM_APAGA = CW'((BLANK > 0) ? BLANK - 1 : 0);

    estado_t       estado;
    logic [2:0]    linha;
    logic [2:0]    ch;
    logic [CW-1:0] cnt;
    logic [4:0]    padrao [0:6];
    logic [2:0]    alvo;
    logic [4:0]    col_alvo;

    assign CH2 = ch[2];
    assign CH1 = ch[1];
    assign CH0 = ch[0];

    // Row entered next: the following row while scanning, otherwise row 1 (start, wrap, after DISP).
    always_comb begin
        alvo = 3'd1;
        if (estado == ACESA && linha != 3'd7)
            alvo = linha + 3'd1;
        col_alvo = ~padrao[3'(alvo - 3'd1)];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado     <= IDLE;
            linha      <= 3'd1;
            ch         <= 3'd0;
            cnt        <= '0;
            valido     <= 1'b1;
            colunas    <= 5'h1f;
            fim_quadro <= 1'b0;
            for (int i = 0; i < 7; i++)
                padrao[i] <= 5'd0;
        end else begin
            fim_quadro <= 1'b0;
            if (wr_en && wr_linha != 3'd0)
                padrao[3'(wr_linha - 3'd1)] <= wr_dados;

            if (!habilita) begin
                estado  <= IDLE;
                linha   <= 3'd1;
                ch      <= 3'd0;
                cnt     <= '0;
                valido  <= 1'b1;
                colunas <= 5'h1f;
            end else begin
                case (estado)
                    IDLE: begin
                        linha <= alvo;
                        ch    <= alvo;
                        cnt   <= '0;
                        if (BLANK == 0) begin
                            estado  <= ACESA;
                            valido  <= 1'b0;
                            colunas <= col_alvo;
                        end else begin
                            estado  <= APAGA;
                            valido  <= 1'b1;
                            colunas <= 5'h1f;
                        end
                    end
                    APAGA: begin
                        if (cnt == FIM_APAGA) begin
                            estado  <= ACESA;
                            cnt     <= '0;
                            valido  <= 1'b0;
                            // Pattern is latched here; later writes to this row wait for its next visit.
                            colunas <= ~padrao[3'(linha - 3'd1)];
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ACESA: begin
                        if (cnt == FIM_ACESA) begin
                            cnt <= '0;
`ifdef MATRIZ_DISPLAY_SLOT_EN
                            if (linha == 3'd7) begin
                                estado     <= DISP;
                                ch         <= 3'd0;
                                valido     <= 1'b0;
                                colunas    <= 5'h1f;
                                fim_quadro <= 1'b1;
                            end else begin
`else
                            begin
                                fim_quadro <= (linha == 3'd7);
`endif
                                linha <= alvo;
                                ch    <= alvo;
                                if (BLANK == 0) begin
                                    estado  <= ACESA;
                                    valido  <= 1'b0;
                                    colunas <= col_alvo;
                                end else begin
                                    estado  <= APAGA;
                                    valido  <= 1'b1;
                                    colunas <= 5'h1f;
                                end
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
`ifdef MATRIZ_DISPLAY_SLOT_EN
                    DISP: begin
                        if (cnt == FIM_ACESA) begin
                            cnt   <= '0;
                            linha <= alvo;
                            ch    <= alvo;
                            if (BLANK == 0) begin
                                estado  <= ACESA;
                                valido  <= 1'b0;
                                colunas <= col_alvo;
                            end else begin
                                estado  <= APAGA;
                                valido  <= 1'b1;
                                colunas <= 5'h1f;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
`endif
                    default: begin
                        estado <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_matriz_varredura.sv
// tb/tb_matriz_varredura.sv - scoreboard bench for matriz_varredura (DIV=2, BLANK=1)
module tb_matriz_varredura;

    localparam int DIV   = 2;
    localparam int BLANK = 1;
    localparam int S     = DIV + BLANK;
`ifdef MATRIZ_DISPLAY_SLOT_EN
    localparam int P = 7 * S + DIV;
`else
    localparam int P = 7 * S;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       habilita;
    logic       wr_en;
    logic [2:0] wr_linha;
    logic [4:0] wr_dados;
    logic       CH2, CH1, CH0;
    logic       valido;
    logic [4:0] colunas;
    logic       fim_quadro;

    matriz_varredura #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk        (clk),
        .reset      (reset),
        .habilita   (habilita),
        .wr_en      (wr_en),
        .wr_linha   (wr_linha),
        .wr_dados   (wr_dados),
        .CH2        (CH2),
        .CH1        (CH1),
        .CH0        (CH0),
        .valido     (valido),
        .colunas    (colunas),
        .fim_quadro (fim_quadro)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int ciclo    = 0;
    int ult_fim  = -1;

    logic [9:0] fila [$];
    logic [4:0] pat [1:7];
    logic [4:0] snap;
    bit         rodando;
    int         t;
    int         m_linha;
    bit         m_acesa;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", tag, ciclo, got, exp);
        end
    endtask

    // Reference model: frame position from cycles since enable; pattern snapshot on lit entry.
    task automatic step();
        logic [9:0] e;
        logic [9:0] obs;
        int p;
        int off;
        m_acesa = 0;
        m_linha = 0;
        if (reset) begin
            for (int k = 1; k <= 7; k++) pat[k] = 5'd0;
            rodando = 0;
            e = {3'd0, 1'b1, 5'h1f, 1'b0};
        end else if (!habilita) begin
            rodando = 0;
            e = {3'd0, 1'b1, 5'h1f, 1'b0};
        end else begin
            if (!rodando) begin
                rodando = 1;
                t = 0;
            end else begin
                t++;
            end
            p = t % P;
            if (p < 7 * S) begin
                m_linha = p / S + 1;
                off = p % S;
                if (off < BLANK) begin
                    e = {3'(m_linha), 1'b1, 5'h1f, 1'b0};
                end else begin
                    if (off == BLANK) snap = ~pat[m_linha];
                    m_acesa = 1;
                    e = {3'(m_linha), 1'b0, snap, 1'b0};
                end
`ifndef MATRIZ_DISPLAY_SLOT_EN
                e[0] = (p == 0 && t > 0);
`endif
            end else begin
                e = {3'd0, 1'b0, 5'h1f, (p == 7 * S)};
            end
        end
        if (!reset && wr_en && wr_linha != 3'd0) pat[wr_linha] = wr_dados;
        fila.push_back(e);
        @(posedge clk);
        @(negedge clk);
        ciclo++;
        obs = {CH2, CH1, CH0, valido, colunas, fim_quadro};
        check("saida{ch,valido,colunas,fim}", 32'(obs), 32'(fila.pop_front()));
        if (!rodando) begin
            ult_fim = -1;
        end else if (fim_quadro) begin
            if (ult_fim >= 0) check("periodo_quadro", 32'(ciclo - ult_fim), 32'(P));
            ult_fim = ciclo;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic seek(input int linha, input string tag);
        bit achou = 0;
        for (int i = 0; i < 3 * P && !achou; i++) begin
            step();
            achou = (m_linha == linha && m_acesa);
        end
        check(tag, 32'(achou), 32'd1);
    endtask

    initial begin
        reset = 1; habilita = 1; wr_en = 1; wr_linha = 3'd3; wr_dados = 5'h1f;
        run(3);
        reset = 0; habilita = 0; wr_en = 0;
        run(2);
        habilita = 1;
        run(P + 4);
        habilita = 0;
        for (int k = 1; k <= 7; k++) begin
            wr_en = 1; wr_linha = 3'(k); wr_dados = 5'(k);
            step();
        end
        wr_en = 0;
        habilita = 1;
        run(2 * P + 1);
        wr_en = 1; wr_linha = 3'd0; wr_dados = 5'h1f;
        step();
        wr_en = 0;
        run(P);
        seek(4, "acha_linha4_acesa");
        wr_en = 1; wr_linha = 3'd4; wr_dados = 5'b10101;
        step();
        wr_en = 0;
        run(P + 2);
        seek(5, "acha_linha5_acesa");
        habilita = 0;
        step();
        habilita = 1;
        run(P + 5);
        for (int i = 0; i < 2 * P; i++) begin
            wr_en = 1'($urandom_range(0, 1));
            wr_linha = 3'($urandom_range(0, 7));
            wr_dados = 5'($urandom_range(0, 31));
            step();
        end
        wr_en = 0;
        run(P);
        reset = 1;
        step();
        reset = 0;
        run(P + 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
